// File: rtl/bky_shift_ctrl_pkg.sv
// Shared definitions for the Buckeye serial shift engine.
package bky_shift_ctrl_pkg;

  // Chip count and per-chip shift-register length on the board.
  localparam int unsigned NBKY     = 6;
  localparam int unsigned BKY_BITS = 48;

  // User function codes that feed this block.
  localparam logic [7:0] BKY_MASK_F  = 8'd10;
  localparam logic [7:0] BKY_SHIFT_F = 8'd11;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StFin
  } bky_state_e;

  // One-cycle strobes broadcast from the sequencer to every lane.
  // The sequencer raises at most one field in any cycle.
  typedef struct packed {
    logic load;     // latch enable and parallel word, park AMPIN on bit 0
    logic rise;     // raise AMPCLK, sample AMPOUT, shift right
    logic fall;     // drop AMPCLK, present the next bit on AMPIN
    logic stop;     // drop AMPCLK and AMPIN after the last bit
    logic capture;  // copy the shift register into the readback slice
  } bky_lane_ctrl_t;

  // True for the function codes this block serves.
  function automatic logic is_bky_func(input logic [7:0] func);
    return (func == BKY_MASK_F) || (func == BKY_SHIFT_F);
  endfunction

endpackage

// File: rtl/bky_lane.sv
// One Buckeye lane: shift register, mask-gated AMPIN/AMPCLK, readback slice.
module bky_lane
  import bky_shift_ctrl_pkg::*;
#(
  parameter int unsigned Nbits = BKY_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  bky_lane_ctrl_t   ctrl_i,
  input  logic             en_i,
  input  logic [Nbits-1:0] wdata_i,
  input  logic             ampout_i,
  output logic             ampin_o,
  output logic             ampclk_o,
  output logic [Nbits-1:0] rdata_o
);

  logic             en_q, en_d;
  logic [Nbits-1:0] sr_q, sr_d;
  logic [Nbits-1:0] rdata_q, rdata_d;
  logic             ampin_q, ampin_d;
  logic             ampclk_q, ampclk_d;

  // Next-state for the lane; a disabled lane never leaves the all-zero pin state.
  always_comb begin
    en_d     = en_q;
    sr_d     = sr_q;
    rdata_d  = rdata_q;
    ampin_d  = ampin_q;
    ampclk_d = ampclk_q;
    if (ctrl_i.load) begin
      en_d     = en_i;
      sr_d     = en_i ? wdata_i : sr_q;
      ampin_d  = en_i & wdata_i[0];
      ampclk_d = 1'b0;
    end else if (en_q) begin
      if (ctrl_i.rise) begin
        // AMPOUT still shows the chip bit from before this AMPCLK edge.
        sr_d     = {ampout_i, sr_q[Nbits-1:1]};
        ampclk_d = 1'b1;
      end else if (ctrl_i.fall) begin
        // AMPIN only moves while AMPCLK is low, so it is stable across the edge.
        ampclk_d = 1'b0;
        ampin_d  = sr_q[0];
      end else if (ctrl_i.stop) begin
        ampclk_d = 1'b0;
        ampin_d  = 1'b0;
      end else if (ctrl_i.capture) begin
        rdata_d = sr_q;
      end
    end
  end

  // Lane state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      sr_q     <= '0;
      rdata_q  <= '0;
      ampin_q  <= 1'b0;
      ampclk_q <= 1'b0;
    end else begin
      en_q     <= en_d;
      sr_q     <= sr_d;
      rdata_q  <= rdata_d;
      ampin_q  <= ampin_d;
      ampclk_q <= ampclk_d;
    end
  end

  assign ampin_o  = ampin_q;
  assign ampclk_o = ampclk_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/bky_shift_ctrl.sv
// Buckeye shift engine: shared sequencer and counters driving one lane per chip.
module bky_shift_ctrl
  import bky_shift_ctrl_pkg::*;
#(
  parameter int unsigned NCHIP   = NBKY,
  parameter int unsigned NBITS   = BKY_BITS,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                   CMSCLK,
  input  logic                   RST_B,
  input  logic                   START,
  input  logic [NCHIP-1:0]       MASK,
  input  logic [NCHIP*NBITS-1:0] WDATA,
  input  logic [NCHIP-1:0]       AMPOUT,
  output logic [NCHIP-1:0]       AMPIN,
  output logic [NCHIP-1:0]       AMPCLK,
  output logic [NCHIP*NBITS-1:0] RDATA,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int unsigned BitW = $clog2(NBITS + 1);
  localparam int unsigned HpW  = $clog2(CLK_DIV + 1);

  localparam logic [BitW-1:0] BitLast = BitW'(NBITS - 1);
  localparam logic [HpW-1:0]  HpLast  = HpW'(CLK_DIV - 1);

  bky_state_e      state_q, state_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [HpW-1:0]  hp_q, hp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  bky_lane_ctrl_t  ctrl;

  // Sequencer: each bit is CLK_DIV cycles low then CLK_DIV cycles high.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    hp_d    = hp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ctrl    = '0;
    unique case (state_q)
      StIdle: begin
        // A request landing on the DONE cycle is dropped.
        if (START && !done_q) begin
          ctrl.load = 1'b1;
          bit_d     = '0;
          hp_d      = '0;
          busy_d    = 1'b1;
          state_d   = (|MASK) ? StLow : StFin;
        end
      end
      StLow: begin
        if (hp_q == HpLast) begin
          hp_d      = '0;
          ctrl.rise = 1'b1;
          state_d   = StHigh;
        end else begin
          hp_d = hp_q + HpW'(1);
        end
      end
      StHigh: begin
        if (hp_q == HpLast) begin
          hp_d  = '0;
          bit_d = bit_q + BitW'(1);
          if (bit_q == BitLast) begin
            ctrl.stop = 1'b1;
            state_d   = StFin;
          end else begin
            ctrl.fall = 1'b1;
            state_d   = StLow;
          end
        end else begin
          hp_d = hp_q + HpW'(1);
        end
      end
      StFin: begin
        ctrl.capture = 1'b1;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and status registers.
  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= StIdle;
      bit_q   <= '0;
      hp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      hp_q    <= hp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < NCHIP; k++) begin : g_lane
    bky_lane #(
      .Nbits(NBITS)
    ) u_lane (
      .clk_i   (CMSCLK),
      .rst_ni  (RST_B),
      .ctrl_i  (ctrl),
      .en_i    (MASK[k]),
      .wdata_i (WDATA[k*NBITS +: NBITS]),
      .ampout_i(AMPOUT[k]),
      .ampin_o (AMPIN[k]),
      .ampclk_o(AMPCLK[k]),
      .rdata_o (RDATA[k*NBITS +: NBITS])
    );
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_bky_shift_ctrl.sv
// Directed bench for bky_shift_ctrl with behavioural 48-bit chip models.
module tb_bky_shift_ctrl;

  localparam int NCHIP   = 6;
  localparam int NBITS   = 48;
  localparam int CLK_DIV = 2;
  localparam int W       = NCHIP * NBITS;
  localparam int LAT     = 2 * CLK_DIV * NBITS + 2;

  logic             CMSCLK;
  logic             RST_B;
  logic             START;
  logic [NCHIP-1:0] MASK;
  logic [W-1:0]     WDATA;
  logic [NCHIP-1:0] AMPOUT;
  logic [NCHIP-1:0] AMPIN;
  logic [NCHIP-1:0] AMPCLK;
  logic [W-1:0]     RDATA;
  logic             BUSY;
  logic             DONE;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NBITS-1:0] chip  [NCHIP];
  logic [31:0]      edges [NCHIP];
  logic [31:0]      snap  [NCHIP];

  bky_shift_ctrl #(
    .NCHIP  (NCHIP),
    .NBITS  (NBITS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .CMSCLK(CMSCLK),
    .RST_B (RST_B),
    .START (START),
    .MASK  (MASK),
    .WDATA (WDATA),
    .AMPOUT(AMPOUT),
    .AMPIN (AMPIN),
    .AMPCLK(AMPCLK),
    .RDATA (RDATA),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CMSCLK = 1'b0;
  always #5 CMSCLK = ~CMSCLK;

  // Chip model: shifts right on rising AMPCLK, AMPOUT is bit 0.
  for (genvar g = 0; g < NCHIP; g++) begin : g_chip
    logic [NBITS-1:0] model_q;
    logic [31:0]      edge_n = 0;
    always @(posedge AMPCLK[g]) begin
      model_q <= {AMPIN[g], model_q[NBITS-1:1]};
      edge_n  <= edge_n + 1;
    end
    assign AMPOUT[g] = model_q[0];
    assign chip[g]   = model_q;
    assign edges[g]  = edge_n;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] chips_now();
    logic [W-1:0] r;
    for (int k = 0; k < NCHIP; k++) r[k*NBITS +: NBITS] = chip[k];
    return r;
  endfunction

  task automatic take_snap();
    for (int k = 0; k < NCHIP; k++) snap[k] = edges[k];
  endtask

  task automatic chk_edges(input string tag, input logic [NCHIP-1:0] m, input int n);
    for (int k = 0; k < NCHIP; k++)
      chk_i($sformatf("%s_lane%0d", tag, k + 1), int'(edges[k] - snap[k]), m[k] ? n : 0);
  endtask

  // Runs one request; extra START pulses at negedge indices ia/ib/ic (0 = none).
  task automatic run_seq(input logic [NCHIP-1:0] m, input logic [W-1:0] wd,
                         input int ia, input int ib, input int ic,
                         output int lat, output int dones,
                         output logic [NCHIP-1:0] dis_act, output int wave_err);
    bit   seen;
    logic e;
    lat      = -1;
    dones    = 0;
    dis_act  = '0;
    wave_err = 0;
    seen     = 1'b0;
    @(negedge CMSCLK);
    START = 1'b1;
    MASK  = m;
    WDATA = wd;
    for (int c = 1; c <= 400; c++) begin
      @(negedge CMSCLK);
      START = (c == ia) || (c == ib) || (c == ic);
      if (START) begin
        MASK  = 6'h01;
        WDATA = '1;
      end
      dis_act |= (AMPCLK | AMPIN) & ~m;
      e = m[0] && (c <= 2 * CLK_DIV * NBITS) && (((c - 1) % (2 * CLK_DIV)) >= CLK_DIV);
      wave_err += int'(AMPCLK[0] !== e);
      if (DONE) begin
        dones++;
        if (!seen) lat = c;
        seen = 1'b1;
      end
      if (seen && c >= lat + 4) break;
    end
    START = 1'b0;
  endtask

  logic [W-1:0]     w1, w2, w3, exp_r, exp_c, rd_save;
  logic [NCHIP-1:0] dis;
  int               lat, dones, werr, cnt;

  initial begin
    for (int k = 0; k < NCHIP; k++) begin
      w1[k*NBITS +: NBITS] = {8'(k + 1), 40'hA5A5A5A5A5};
      w2[k*NBITS +: NBITS] = {24'hC0FFEE, 16'(k * 16'h1111), 8'h5A};
    end
    w3 = ~w1;

    // Reset state.
    RST_B = 1'b0;
    START = 1'b0;
    MASK  = '0;
    WDATA = '0;
    repeat (3) @(negedge CMSCLK);
    chk_i("rst_ampclk", int'(AMPCLK), 0);
    chk_i("rst_ampin", int'(AMPIN), 0);
    chk("rst_rdata", RDATA, '0);
    chk_i("rst_busy", int'(BUSY), 0);
    chk_i("rst_done", int'(DONE), 0);
    RST_B = 1'b1;
    repeat (2) @(negedge CMSCLK);

    // Echo: load every chip with its own word, also checking AMPCLK timing.
    take_snap();
    run_seq(6'h3F, w1, 0, 0, 0, lat, dones, dis, werr);
    chk_i("echo_latency", lat, LAT);
    chk_i("echo_dones", dones, 1);
    chk_i("echo_ampclk_wave", werr, 0);
    chk_edges("echo_edges", 6'h3F, NBITS);
    chk("echo_chips", chips_now(), w1);
    chk_i("echo_busy_after", int'(BUSY), 0);

    // Re-shift zeros: readback is the first pattern.
    run_seq(6'h3F, '0, 0, 0, 0, lat, dones, dis, werr);
    chk("reshift_rdata", RDATA, w1);
    chk("reshift_chips", chips_now(), '0);
    chk_i("reshift_latency", lat, LAT);

    // Mask lanes 1 and 3 only.
    take_snap();
    run_seq(6'b000101, w2, 0, 0, 0, lat, dones, dis, werr);
    exp_r = w1;
    exp_r[0*NBITS +: NBITS] = '0;
    exp_r[2*NBITS +: NBITS] = '0;
    exp_c = '0;
    exp_c[0*NBITS +: NBITS] = w2[0*NBITS +: NBITS];
    exp_c[2*NBITS +: NBITS] = w2[2*NBITS +: NBITS];
    chk_edges("mask_edges", 6'b000101, NBITS);
    chk_i("mask_disabled_pins", int'(dis), 0);
    chk("mask_rdata", RDATA, exp_r);
    chk("mask_chips", chips_now(), exp_c);
    chk_i("mask_latency", lat, LAT);

    // MASK=0: immediate DONE, no clocks, readback untouched.
    rd_save = RDATA;
    take_snap();
    run_seq(6'h00, '1, 0, 0, 0, lat, dones, dis, werr);
    chk_i("mask0_latency", lat, 2);
    chk_i("mask0_dones", dones, 1);
    chk_edges("mask0_edges", 6'h3F, 0);
    chk_i("mask0_pins", int'(dis), 0);
    chk("mask0_rdata", RDATA, rd_save);

    // START at cycles 10, 150 and on the DONE cycle: all ignored.
    take_snap();
    run_seq(6'h3F, w3, 10, 150, LAT, lat, dones, dis, werr);
    chk_i("ign_latency", lat, LAT);
    chk_i("ign_dones", dones, 1);
    chk_edges("ign_edges", 6'h3F, NBITS);
    chk("ign_chips", chips_now(), w3);
    chk_i("ign_busy_after", int'(BUSY), 0);

    // Reset after 20 AMPCLK edges.
    take_snap();
    @(negedge CMSCLK);
    START = 1'b1;
    MASK  = 6'h3F;
    WDATA = w1;
    @(negedge CMSCLK);
    START = 1'b0;
    cnt = 0;
    while (int'(edges[0] - snap[0]) < 20 && cnt < 300) begin
      @(negedge CMSCLK);
      cnt++;
    end
    chk_i("rstmid_edges_reached", int'(edges[0] - snap[0]), 20);
    RST_B = 1'b0;
    #1;
    chk_i("rstmid_ampclk", int'(AMPCLK), 0);
    chk_i("rstmid_busy", int'(BUSY), 0);
    chk("rstmid_rdata", RDATA, '0);
    dones = 0;
    repeat (10) begin
      @(negedge CMSCLK);
      dones += int'(DONE);
    end
    RST_B = 1'b1;
    repeat (200) begin
      @(negedge CMSCLK);
      dones += int'(DONE);
    end
    chk_i("rstmid_no_done", dones, 0);

    take_snap();
    run_seq(6'h3F, w2, 0, 0, 0, lat, dones, dis, werr);
    chk_i("rerun_latency", lat, LAT);
    chk_edges("rerun_edges", 6'h3F, NBITS);
    chk("rerun_chips", chips_now(), w2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
